shift_exec_pipe: RTL and testbench

- Two-stage pipelined execute-stage shift unit for the MIPS-style datapath.
- Decodes the shift funct code and selects the shift amount: immediate shamt or rs[4:0].
- Drives the combinational barrel shifter and registers the result for writeback.
- Uses a valid/ready handshake on both sides and supports a pipeline flush.

---
 rtl/shift_exec_pkg.sv | 22 ++
 rtl/shift_exec_pipe_core.sv | 40 ++++
 rtl/shift_exec_pipe.sv | 180 ++++++++++++++++++
 tb/tb_shift_exec_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_exec_pkg.sv
// Shared definitions for the execute-stage shift unit: funct codes,
// shifter modes and the default datapath width.
// Optional rotate support is enabled by defining SHIFT_EXEC_ROTATE_EN.
package shift_exec_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        SH_LL  = 2'd0,
        SH_RL  = 2'd1,
        SH_RA  = 2'd2,
        SH_ROR = 2'd3
    } sh_mode_e;

endpackage

// File: rtl/shift_exec_pipe_core.sv
// Combinational 5-level logarithmic shifter. Left shifts reuse the
// right-shift network by bit-reversing the operand on the way in and out.
module shift_core
    import shift_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic [4:0]       amt,
    input  sh_mode_e         mode,
    output logic [WIDTH-1:0] shifted
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0] stage;
    logic             fill;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Each level shifts right by 2^k when amt[k] is set; fill depends on mode.
    always_comb begin
        stage = (mode == SH_LL) ? bitrev(value) : value;
        fill  = (mode == SH_RA) && value[WIDTH-1];
        for (int k = 0; k < 5; k++) begin
            if (amt[k]) begin
                if (mode == SH_ROR)
                    stage = (stage >> (1 << k)) | (stage << (WIDTH - (1 << k)));
                else
                    stage = (stage >> (1 << k)) | (fill ? ~(ONES >> (1 << k)) : '0);
            end
        end
        shifted = (mode == SH_LL) ? bitrev(stage) : stage;
    end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage execute shift unit: stage 1 holds the decoded op, stage 2 holds
// the shifted result. Valid/ready on both sides plus a synchronous flush.
// Define SHIFT_EXEC_ROTATE_EN to turn SRL/SRLV with rot=1 into ROTR/ROTRV.
module shift_exec_pipe
    import shift_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic             rot,
    input  logic [4:0]       shamt,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    // Decode
    sh_mode_e   dec_mode;
    logic       dec_var;
    logic       dec_ill;
    logic [4:0] dec_amt;

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    logic [4:0]       s1_amt_q, s1_amt_d;
    logic             s1_dir_q, s1_dir_d;
    logic             s1_arith_q, s1_arith_d;
    logic             s1_ror_q, s1_ror_d;
    logic             s1_ill_q, s1_ill_d;
    logic [WIDTH-1:0] s1_rt_q, s1_rt_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Stage 2
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_ill_q, s2_ill_d;

    logic             s1_adv, s2_adv, accept;
    sh_mode_e         s1_mode;
    logic [WIDTH-1:0] core_out;

    // Only the low five bits of rs select an amount; rot is dead without rotate.
    logic unused_inputs;
    assign unused_inputs = ^{rot, rs_val[WIDTH-1:5]};

    // Funct decode and shift-amount source select.
    always_comb begin
        dec_mode = SH_RL;
        dec_var  = 1'b0;
        dec_ill  = 1'b0;
        case (funct)
            F_SLL:  dec_mode = SH_LL;
`ifdef SHIFT_EXEC_ROTATE_EN
            F_SRL:  dec_mode = rot ? SH_ROR : SH_RL;
`else
            F_SRL:  dec_mode = SH_RL;
`endif
            F_SRA:  dec_mode = SH_RA;
            F_SLLV: begin dec_mode = SH_LL; dec_var = 1'b1; end
`ifdef SHIFT_EXEC_ROTATE_EN
            F_SRLV: begin dec_mode = rot ? SH_ROR : SH_RL; dec_var = 1'b1; end
`else
            F_SRLV: begin dec_mode = SH_RL; dec_var = 1'b1; end
`endif
            F_SRAV: begin dec_mode = SH_RA; dec_var = 1'b1; end
            default: dec_ill = 1'b1;
        endcase
        dec_amt = dec_var ? rs_val[4:0] : shamt;
    end

    // A stage may move when the stage after it is empty or draining.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv && !flush;
        accept   = in_valid && in_ready;
    end

    // Rebuild the shifter mode from the decoded flags held in stage 1.
    always_comb begin
        if (s1_ror_q)        s1_mode = SH_ROR;
        else if (s1_dir_q)   s1_mode = SH_LL;
        else if (s1_arith_q) s1_mode = SH_RA;
        else                 s1_mode = SH_RL;
    end

    shift_core #(.WIDTH(WIDTH)) u_core (
        .value   (s1_rt_q),
        .amt     (s1_amt_q),
        .mode    (s1_mode),
        .shifted (core_out)
    );

    // Next-state for both pipeline stages; flush empties them at the next edge.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_amt_d   = s1_amt_q;
        s1_dir_d   = s1_dir_q;
        s1_arith_d = s1_arith_q;
        s1_ror_d   = s1_ror_q;
        s1_ill_d   = s1_ill_q;
        s1_rt_d    = s1_rt_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_tag_d   = s2_tag_q;
        s2_ill_d   = s2_ill_q;

        if (flush)       s1_valid_d = 1'b0;
        else if (s1_adv) s1_valid_d = accept;

        if (accept) begin
            s1_amt_d   = dec_amt;
            s1_dir_d   = (dec_mode == SH_LL);
            s1_arith_d = (dec_mode == SH_RA);
            s1_ror_d   = (dec_mode == SH_ROR);
            s1_ill_d   = dec_ill;
            s1_rt_d    = rt_val;
            s1_tag_d   = rd_tag;
        end

        if (flush)       s2_valid_d = 1'b0;
        else if (s2_adv) s2_valid_d = s1_valid_q;

        if (s2_adv && s1_valid_q) begin
            s2_res_d = s1_ill_q ? '0 : core_out;
            s2_tag_d = s1_tag_q;
            s2_ill_d = s1_ill_q;
        end
    end

    // Pipeline registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_amt_q   <= '0;
            s1_dir_q   <= 1'b0;
            s1_arith_q <= 1'b0;
            s1_ror_q   <= 1'b0;
            s1_ill_q   <= 1'b0;
            s1_rt_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_tag_q   <= '0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_amt_q   <= s1_amt_d;
            s1_dir_q   <= s1_dir_d;
            s1_arith_q <= s1_arith_d;
            s1_ror_q   <= s1_ror_d;
            s1_ill_q   <= s1_ill_d;
            s1_rt_q    <= s1_rt_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_tag_q   <= s2_tag_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign out_tag   = s2_tag_q;
    assign illegal   = s2_ill_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: directed cases plus randomized
// traffic scored against a queue-based reference model.
module tb_shift_exec_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  funct = '0;
    logic        rot = 1'b0;
    logic [4:0]  shamt = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic [4:0]  rd_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        illegal;

    int tests = 0;
    int fails = 0;
    int n_fired = 0;
    logic last_acc;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];

    shift_exec_pipe #(.WIDTH(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .rot       (rot),
        .shamt     (shamt),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .rd_tag    (rd_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic rot_on(input logic r);
`ifdef SHIFT_EXEC_ROTATE_EN
        return r;
`else
        return 1'b0 & r;
`endif
    endfunction

    // Reference: MIPS shift semantics written directly with shift operators.
    function automatic exp_t model(input logic [5:0] f, input logic r, input logic [4:0] sa,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] tg);
        exp_t e;
        int   v;
        v = int'(rs[4:0]);
        e.tag = tg;
        e.ill = 1'b0;
        e.res = '0;
        case (f)
            6'd0: e.res = rt << sa;
            6'd2: e.res = rot_on(r) ? ror32(rt, int'(sa)) : rt >> sa;
            6'd3: e.res = $signed(rt) >>> sa;
            6'd4: e.res = rt << v;
            6'd6: e.res = rot_on(r) ? ror32(rt, v) : rt >> v;
            6'd7: e.res = $signed(rt) >>> v;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One clock: score visible output, then track accept/transfer/flush at the edge.
    task automatic cycle();
        logic fire, acc, fl;
        exp_t e;
        @(negedge clk);
        if (q.size() == 0) chk("idle_out_valid", out_valid, 0);
        else if (out_valid) begin
            chk("sb_result", result, q[0].res);
            chk("sb_tag", out_tag, q[0].tag);
            chk("sb_illegal", illegal, q[0].ill);
        end
        fire = out_valid && out_ready && (q.size() > 0);
        acc  = in_valid && in_ready;
        fl   = flush;
        e    = model(funct, rot, shamt, rs_val, rt_val, rd_tag);
        @(posedge clk);
        if (fire) begin q.pop_front(); n_fired++; end
        if (fl) q.delete();
        if (acc) q.push_back(e);
        last_acc = acc;
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic r, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] tg);
        funct = f; rot = r; shamt = sa; rs_val = rs; rt_val = rt; rd_tag = tg;
    endtask

    task automatic rand_legal(input logic [4:0] tg);
        logic [5:0] fl [6];
        fl = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
        drive(fl[$urandom_range(0, 5)], 1'($urandom), 5'($urandom), $urandom, $urandom, tg);
    endtask

    task automatic rand_any();
        rand_legal(5'($urandom));
        if ($urandom_range(0, 7) == 0) funct = 6'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        chk("drain_timeout", q.size(), 0);
        cycle();
    endtask

    task automatic issue_expect(input string name, input logic [5:0] f, input logic r,
                                input logic [4:0] sa, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [4:0] tg,
                                input logic [31:0] er, input logic ei);
        out_ready = 1'b1; flush = 1'b0;
        drive(f, r, sa, rs, rt, tg);
        in_valid = 1'b1;
        chk({name, "_in_ready"}, in_ready, 1);
        cycle();
        in_valid = 1'b0;
        chk({name, "_lat1_valid"}, out_valid, 0);
        cycle();
        chk({name, "_lat2_valid"}, out_valid, 1);
        chk({name, "_result"}, result, er);
        chk({name, "_illegal"}, illegal, ei);
        chk({name, "_tag"}, out_tag, tg);
        cycle();
    endtask

    initial begin
        int cnt, first, last, idx, fired0;
        logic [31:0] bp_rt [3];

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_illegal", illegal, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed single ops
        issue_expect("sll31", 6'b000000, 1'b0, 5'd31, 32'h0, 32'h0000_0001, 5'd3, 32'h8000_0000, 1'b0);
        issue_expect("srav4", 6'b000111, 1'b0, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b0);
        issue_expect("srlv4", 6'b000110, 1'b0, 5'd0, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd5, 32'h0800_000F, 1'b0);
        issue_expect("sra0",  6'b000011, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 5'd6, 32'hDEAD_BEEF, 1'b0);
        issue_expect("illeg", 6'b100000, 1'b0, 5'd7, 32'h0, 32'hFFFF_FFFF, 5'd7, 32'h0, 1'b1);
`ifdef SHIFT_EXEC_ROTATE_EN
        issue_expect("ror4", 6'b000010, 1'b1, 5'd4, 32'h0, 32'h1234_5678, 5'd8, 32'h8123_4567, 1'b0);
`else
        issue_expect("srl_rot_ign", 6'b000010, 1'b1, 5'd4, 32'h0, 32'h1234_5678, 5'd8, 32'h0123_4567, 1'b0);
`endif

        // Back-to-back: four ops on consecutive cycles
        out_ready = 1'b1; cnt = 0; first = -1; last = -1;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin rand_legal(5'(i + 8)); in_valid = 1'b1; end
            else in_valid = 1'b0;
            cycle();
            if (out_valid) begin cnt++; if (first < 0) first = i; last = i; end
        end
        chk("b2b_count", cnt, 4);
        chk("b2b_first", first, 1);
        chk("b2b_contig", last - first, 3);
        drain();

        // Backpressure: three ops offered while the consumer stalls
        out_ready = 1'b0; idx = 0; fired0 = n_fired;
        for (int i = 0; i < 3; i++) bp_rt[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            drive(6'd0, 1'b0, 5'(i + 1), 32'h0, bp_rt[idx], 5'(idx + 16));
            in_valid = 1'b1;
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", in_ready, 0);
        cycle(); cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            drive(6'd0, 1'b0, 5'(idx + 1), 32'h0, bp_rt[idx], 5'(idx + 16));
            in_valid = 1'b1;
            cycle();
            if (last_acc) idx++;
        end
        chk("bp_third_accepted", idx, 3);
        drain();
        chk("bp_fired", n_fired - fired0, 3);

        // Flush with two ops in flight and a third offered
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin rand_legal(5'(i + 20)); in_valid = 1'b1; cycle(); end
        rand_legal(5'd22); in_valid = 1'b1; flush = 1'b1;
        chk("flush_in_ready", in_ready, 0);
        cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", out_valid, 0);
        cycle(); cycle(); cycle();

        // Flush coinciding with an output transfer
        out_ready = 1'b1; fired0 = n_fired;
        for (int i = 0; i < 2; i++) begin rand_legal(5'(i + 24)); in_valid = 1'b1; cycle(); end
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_fire_count", n_fired - fired0, 1);
        chk("flush_fire_empty", out_valid, 0);
        cycle(); cycle();

        // Async reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_legal(5'(i + 28)); in_valid = 1'b1; cycle(); end
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_out_tag", out_tag, 0);
        chk("arst_illegal", illegal, 0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle(); cycle();

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 400; i++) begin
            rand_any();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
